// File: rtl/accel_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : accel_op_scheduler
// Description : In-order command scheduler for the accelerator compute
//               engines (matmul, norm, activation). Commands are buffered in
//               a small FIFO and dispatched one at a time over a start/done
//               handshake. A watchdog flags an engine that never completes.
// Ports       :
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/ready/op/cfg   command push interface (op 0=MATMUL 1=NORM
//                            2=ACT 3=BARRIER)
//   mm_start / mm_done       matmul engine handshake
//   norm_start / norm_done   norm engine handshake
//   act_start / act_done     activation engine handshake
//   eng_cfg                  config word of the op being executed
//   busy                     scheduler active or commands pending
//   err_timeout, err_clear   sticky watchdog error and its clear/flush
//   ops_completed            retired-op counter (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module accel_op_scheduler #(
    parameter int FIFO_DEPTH  = 4,
    parameter int CFG_W       = 16,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CFG_W-1:0] cmd_cfg,
    output logic             mm_start,
    input  logic             mm_done,
    output logic             norm_start,
    input  logic             norm_done,
    output logic             act_start,
    input  logic             act_done,
    output logic [CFG_W-1:0] eng_cfg,
    output logic             busy,
    output logic             err_timeout,
    input  logic             err_clear,
    output logic [CNT_W-1:0] ops_completed
);

    localparam int c_ADDR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_WD_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [c_ADDR_W:0] c_DEPTH   = (c_ADDR_W+1)'(FIFO_DEPTH);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] c_OP_MATMUL  = 2'd0;
    localparam logic [1:0] c_OP_NORM    = 2'd1;
    localparam logic [1:0] c_OP_ACT     = 2'd2;
    localparam logic [1:0] c_OP_BARRIER = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------
    // Command FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [1:0]        r_op_mem  [FIFO_DEPTH];
    logic [CFG_W-1:0]  r_cfg_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_count;
    logic [c_ADDR_W:0]   w_count_nxt;
    logic                r_full;
    logic                w_empty;
    logic                w_push;
    logic [1:0]          w_head_op;
    logic [CFG_W-1:0]    w_head_cfg;

    // Control strobes produced by the FSM decode
    logic w_pop;
    logic w_retire;
    logic w_timeout;
    logic w_flush;
    logic w_sel_done;

    // Execution state
    logic [1:0]        r_cur_op;
    logic [CFG_W-1:0]  r_eng_cfg;
    logic [c_WD_W-1:0] r_wd;
    logic              r_err;
    logic [CNT_W-1:0]  r_ops;
    logic              r_mm_start;
    logic              r_norm_start;
    logic              r_act_start;

    assign w_empty    = (r_count == '0);
    assign cmd_ready  = !r_full && (r_state != ST_ERROR);
    assign w_push     = cmd_valid && cmd_ready;
    assign w_head_op  = r_op_mem[r_rd_ptr];
    assign w_head_cfg = r_cfg_mem[r_rd_ptr];

    // Only the done of the engine owning the current op may retire it.
    always_comb begin
        w_sel_done = 1'b0;
        case (r_cur_op)
            c_OP_MATMUL: w_sel_done = mm_done;
            c_OP_NORM:   w_sel_done = norm_done;
            c_OP_ACT:    w_sel_done = act_done;
            default:     w_sel_done = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_retire    = 1'b0;
        w_timeout   = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (r_cur_op == c_OP_BARRIER) begin
                    w_retire    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A done arriving on the last allowed cycle still retires.
                if (w_sel_done) begin
                    w_retire    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_wd == c_WD_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_ERROR;
                end
            end
            ST_ERROR: begin
                if (err_clear) begin
                    w_flush     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO occupancy
    // ------------------------------------------------------------------
    always_comb begin
        w_count_nxt = r_count;
        if (w_flush) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_DEPTH);
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
        end
    end

    // Payload storage needs no reset: entries are only read once counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_op_mem[r_wr_ptr]  <= cmd_op;
            r_cfg_mem[r_wr_ptr] <= cmd_cfg;
        end
    end

    // ------------------------------------------------------------------
    // Current op, engine config and start pulses
    // ------------------------------------------------------------------
    // Starts are registered off the pop so they are high exactly during
    // the ISSUE cycle; a barrier pop raises none of them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_op     <= c_OP_MATMUL;
            r_eng_cfg    <= '0;
            r_mm_start   <= 1'b0;
            r_norm_start <= 1'b0;
            r_act_start  <= 1'b0;
        end else begin
            r_mm_start   <= w_pop && (w_head_op == c_OP_MATMUL);
            r_norm_start <= w_pop && (w_head_op == c_OP_NORM);
            r_act_start  <= w_pop && (w_head_op == c_OP_ACT);
            if (w_pop) begin
                r_cur_op  <= w_head_op;
                r_eng_cfg <= w_head_cfg;
            end
        end
    end

    // ------------------------------------------------------------------
    // Watchdog, sticky error and retired-op counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd  <= '0;
            r_err <= 1'b0;
            r_ops <= '0;
        end else begin
            if (r_state == ST_ISSUE) begin
                r_wd <= '0;
            end else if ((r_state == ST_WAIT) && !w_sel_done && !w_timeout) begin
                r_wd <= r_wd + 1'b1;
            end

            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (w_flush) begin
                r_err <= 1'b0;
            end

            if (w_retire) begin
                r_ops <= r_ops + 1'b1;
            end
        end
    end

    assign mm_start      = r_mm_start;
    assign norm_start    = r_norm_start;
    assign act_start     = r_act_start;
    assign eng_cfg       = r_eng_cfg;
    assign err_timeout   = r_err;
    assign ops_completed = r_ops;
    assign busy          = (r_state != ST_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_accel_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_accel_op_scheduler
// Description : Directed self-checking bench for accel_op_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accel_op_scheduler;

    localparam int CFG_W = 16;
    localparam int CNT_W = 16;
    localparam int TO    = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'd0;
    logic [CFG_W-1:0] cmd_cfg = '0;
    logic             mm_start;
    logic             mm_done = 1'b0;
    logic             norm_start;
    logic             norm_done = 1'b0;
    logic             act_start;
    logic             act_done = 1'b0;
    logic [CFG_W-1:0] eng_cfg;
    logic             busy;
    logic             err_timeout;
    logic             err_clear = 1'b0;
    logic [CNT_W-1:0] ops_completed;

    int total = 0;
    int bad   = 0;

    accel_op_scheduler #(
        .FIFO_DEPTH (4),
        .CFG_W      (CFG_W),
        .TIMEOUT_CYC(TO),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_cfg      (cmd_cfg),
        .mm_start     (mm_start),
        .mm_done      (mm_done),
        .norm_start   (norm_start),
        .norm_done    (norm_done),
        .act_start    (act_start),
        .act_done     (act_done),
        .eng_cfg      (eng_cfg),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .err_clear    (err_clear),
        .ops_completed(ops_completed)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] starts();
        return {mm_start, norm_start, act_start};
    endfunction

    // Present one command for one cycle; it must be accepted.
    task automatic push(input string tag, input logic [1:0] op, input logic [15:0] cfg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cfg   = cfg;
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for the next start pulse and check which engine and cfg.
    task automatic wait_start(input string tag, input logic [1:0] op, input logic [15:0] cfg);
        int n;
        logic [2:0] exp_vec;
        n = 0;
        while ((starts() == 3'b000) && (n < 20)) begin
            tick();
            n++;
        end
        exp_vec = (op == 2'd0) ? 3'b100 : (op == 2'd1) ? 3'b010 : 3'b001;
        check({tag, "_start"}, 32'(starts()), 32'(exp_vec));
        check({tag, "_cfg"}, 32'(eng_cfg), 32'(cfg));
    endtask

    // From the ISSUE cycle: two WAIT cycles, then the matching done pulse.
    task automatic finish_op(input logic [1:0] op);
        tick();
        tick();
        mm_done   = (op == 2'd0);
        norm_done = (op == 2'd1);
        act_done  = (op == 2'd2);
        tick();
        mm_done   = 1'b0;
        norm_done = 1'b0;
        act_done  = 1'b0;
    endtask

    initial begin
        int base;
        logic seen;

        // ---------------- Reset state ----------------
        rst = 1'b1;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ops", 32'(ops_completed), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_cfg", 32'(eng_cfg), 32'd0);
        check("rst_starts", 32'(starts()), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);

        // ---------------- Test 1: single MATMUL latency ----------------
        rst       = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_cfg   = 16'h1234;               // cycle 0
        tick();                             // cycle 1
        cmd_valid = 1'b0;
        check("t1_c1_starts", 32'(starts()), 32'd0);
        check("t1_c1_busy", 32'(busy), 32'd1);
        tick();                             // cycle 2
        check("t1_c2_starts", 32'(starts()), 32'b100);
        check("t1_c2_cfg", 32'(eng_cfg), 32'h1234);
        tick();                             // cycle 3
        check("t1_c3_starts", 32'(starts()), 32'd0);
        tick();
        tick();
        tick();                             // cycle 6
        mm_done = 1'b1;
        check("t1_c6_ops", 32'(ops_completed), 32'd0);
        tick();                             // cycle 7
        mm_done = 1'b0;
        check("t1_c7_ops", 32'(ops_completed), 32'd1);
        check("t1_c7_busy", 32'(busy), 32'd0);
        check("t1_c7_cfg_held", 32'(eng_cfg), 32'h1234);

        // ---------------- Test 2: full FIFO and in-order dispatch ----------------
        base = int'(ops_completed);
        push("t2_blk_push", 2'd0, 16'h00AA);
        wait_start("t2_blk", 2'd0, 16'h00AA);
        tick();                             // blocker now in WAIT
        push("t2_p1", 2'd1, 16'h0101);
        push("t2_p2", 2'd2, 16'h0202);
        push("t2_p3", 2'd3, 16'h0303);
        push("t2_p4", 2'd0, 16'h0404);
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_cfg   = 16'h0505;
        check("t2_full_ready", 32'(cmd_ready), 32'd0);
        tick();
        cmd_valid = 1'b0;
        check("t2_full_busy", 32'(busy), 32'd1);
        mm_done = 1'b1;
        tick();
        mm_done = 1'b0;
        wait_start("t2_norm", 2'd1, 16'h0101);
        finish_op(2'd1);
        wait_start("t2_act", 2'd2, 16'h0202);
        finish_op(2'd2);
        wait_start("t2_mm", 2'd0, 16'h0404);
        finish_op(2'd0);
        check("t2_ops", 32'(ops_completed), 32'(base + 5));
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (starts() != 3'b000) seen = 1'b1;
        end
        check("t2_no_extra_start", 32'(seen), 32'd0);
        check("t2_idle_busy", 32'(busy), 32'd0);

        // ---------------- Test 3: foreign dones ignored ----------------
        base = int'(ops_completed);
        push("t3_push", 2'd2, 16'h0033);
        wait_start("t3", 2'd2, 16'h0033);
        act_done = 1'b1;                    // done coincident with start: ignored
        tick();
        act_done  = 1'b0;
        mm_done   = 1'b1;
        norm_done = 1'b1;
        check("t3_issue_done_ignored", 32'(ops_completed), 32'(base));
        tick();
        mm_done   = 1'b0;
        norm_done = 1'b0;
        check("t3_foreign_ops", 32'(ops_completed), 32'(base));
        check("t3_foreign_busy", 32'(busy), 32'd1);
        tick();
        act_done = 1'b1;
        tick();
        act_done = 1'b0;
        check("t3_retire_ops", 32'(ops_completed), 32'(base + 1));
        check("t3_retire_busy", 32'(busy), 32'd0);

        // ---------------- Test 4: watchdog timeout and err_clear ----------------
        base = int'(ops_completed);
        push("t4_push_mm", 2'd0, 16'h4444);
        wait_start("t4", 2'd0, 16'h4444);   // ISSUE cycle S
        push("t4_push_norm", 2'd1, 16'h4401); // -> S+1
        push("t4_push_act", 2'd2, 16'h4402);  // -> S+2
        for (int i = 0; i < TO - 2; i++) tick(); // -> S+TO, last WAIT cycle
        check("t4_err_before", 32'(err_timeout), 32'd0);
        tick();
        check("t4_err_set", 32'(err_timeout), 32'd1);
        check("t4_err_ready", 32'(cmd_ready), 32'd0);
        check("t4_err_busy", 32'(busy), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (starts() != 3'b000) seen = 1'b1;
        end
        check("t4_err_no_start", 32'(seen), 32'd0);
        check("t4_err_sticky", 32'(err_timeout), 32'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("t4_clr_err", 32'(err_timeout), 32'd0);
        check("t4_clr_busy", 32'(busy), 32'd0);
        check("t4_clr_ready", 32'(cmd_ready), 32'd1);
        check("t4_clr_ops", 32'(ops_completed), 32'(base));
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (starts() != 3'b000) seen = 1'b1;
        end
        check("t4_flushed_no_start", 32'(seen), 32'd0);

        // ---------------- Test 5: done on the last allowed WAIT cycle ----------------
        base = int'(ops_completed);
        push("t5_push", 2'd0, 16'h5555);
        wait_start("t5", 2'd0, 16'h5555);
        for (int i = 0; i < TO - 1; i++) tick();
        tick();                             // WAIT cycle number TO
        mm_done = 1'b1;
        tick();
        mm_done = 1'b0;
        check("t5_err", 32'(err_timeout), 32'd0);
        check("t5_ops", 32'(ops_completed), 32'(base + 1));
        check("t5_busy", 32'(busy), 32'd0);

        // ---------------- Test 6: reset mid-operation ----------------
        push("t6_push_mm", 2'd0, 16'h6666);
        wait_start("t6", 2'd0, 16'h6666);
        push("t6_push_norm", 2'd1, 16'h6601);
        push("t6_push_act", 2'd2, 16'h6602);
        check("t6_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_ops", 32'(ops_completed), 32'd0);
        check("t6_err", 32'(err_timeout), 32'd0);
        check("t6_ready", 32'(cmd_ready), 32'd1);
        check("t6_cfg", 32'(eng_cfg), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (starts() != 3'b000) seen = 1'b1;
        end
        check("t6_no_start", 32'(seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
